// File: rtl/cpu_pkg.sv
// Shared constants for the single-cycle MIPS datapath: datapath width,
// the immediate-opcode values that select zero-extension, and the
// architecturally fixed register indices.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile32.sv
// General register file: two asynchronous read ports, one write port that
// commits on the rising clock edge, asynchronous active-low clear.
// Register 0 is never written and always reads as zero.
module regfile32
    import cpu_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = cpu_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // Clear everything while reset is low; otherwise commit the write,
    // dropping any write aimed at register 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads have no bypass: a same-cycle write becomes visible after its edge.
    assign rdata1 = (raddr1 == REG_ZERO) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == REG_ZERO) ? '0 : regs[raddr2];

endmodule

// File: rtl/idecode32.sv
// Decode / write-back stage: register file access for rs and rt, immediate
// extension, and selection of the write-back address and data (ALU result,
// load data, or the jal link value).
module idecode32
    import cpu_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = cpu_pkg::DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       Instruction,
    input  logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] opcplus4,
    input  logic              Jal,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              RegDst,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic [DATA_W-1:0] Sign_extend
);

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              zero_ext;

    assign opcode = Instruction[31:26];
    assign rs     = Instruction[25:21];
    assign rt     = Instruction[20:16];
    assign rd     = Instruction[15:11];
    assign imm    = Instruction[15:0];

    // jal writes $31 even when RegWrite is low.
    assign wr_en = RegWrite | Jal;

    // Destination and source selection; jal overrides both RegDst and MemtoReg.
    always_comb begin
        wr_addr = rt;
        wr_data = ALU_result;
        if (Jal) begin
            wr_addr = REG_RA;
            wr_data = opcplus4;
        end else begin
            if (RegDst) begin
                wr_addr = rd;
            end
            if (MemtoReg) begin
                wr_data = read_data;
            end
        end
    end

    // Logical immediates are zero-extended; every other opcode sign-extends.
    always_comb begin
        zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        if (zero_ext) begin
            Sign_extend = {{(DATA_W-16){1'b0}}, imm};
        end else begin
            Sign_extend = {{(DATA_W-16){imm[15]}}, imm};
        end
    end

    regfile32 #(
        .REG_COUNT (REG_COUNT),
        .DATA_W    (DATA_W)
    ) u_regfile (
        .clock  (clock),
        .reset  (reset),
        .raddr1 (rs),
        .raddr2 (rt),
        .we     (wr_en),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .rdata1 (read_data_1),
        .rdata2 (read_data_2)
    );

endmodule

// File: tb/tb_idecode32.sv
// Bench for idecode32: a table of directed vectors, each applied at the
// falling edge and checked before the following rising edge, plus
// hand-written sequences for reset behaviour.
module tb_idecode32;

    logic        clock;
    logic        reset;
    logic [31:0] Instruction;
    logic [31:0] read_data;
    logic [31:0] ALU_result;
    logic [31:0] opcplus4;
    logic        Jal;
    logic        RegWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic [31:0] Sign_extend;

    int n_checks;
    int n_fail;

    idecode32 dut (
        .clock       (clock),
        .reset       (reset),
        .Instruction (Instruction),
        .read_data   (read_data),
        .ALU_result  (ALU_result),
        .opcplus4    (opcplus4),
        .Jal         (Jal),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .Sign_extend (Sign_extend)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] opc4;
        logic        jal;
        logic        rw;
        logic        m2r;
        logic        rdst;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] esx;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [4:0] rd_f);
        return {op, rs_f, rt_f, rd_f, 11'h000};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm_f);
        return {op, rs_f, rt_f, imm_f};
    endfunction

    task automatic add(input string nm, input logic [31:0] instr, input logic [31:0] rdata,
                       input logic [31:0] alu, input logic [31:0] opc4, input logic jal,
                       input logic rw, input logic m2r, input logic rdst,
                       input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] esx);
        vec_t v;
        v.name = nm; v.instr = instr; v.rdata = rdata; v.alu = alu; v.opc4 = opc4;
        v.jal = jal; v.rw = rw; v.m2r = m2r; v.rdst = rdst;
        v.e1 = e1; v.e2 = e2; v.esx = esx;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rdata, input logic [31:0] alu,
                         input logic [31:0] opc4, input logic jal, input logic rw,
                         input logic m2r, input logic rdst);
        Instruction = instr; read_data = rdata; ALU_result = alu; opcplus4 = opc4;
        Jal = jal; RegWrite = rw; MemtoReg = m2r; RegDst = rdst;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1 reset = 1'b0;

        // Reset held: a pending write must not land, every register reads 0.
        drive(itype(6'h0D, 5'd5, 5'd6, 16'h8001), 32'h0, 32'h0000_00AA, 32'h0,
              1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("reset_rs5", read_data_1, 32'h0);
        check("reset_rt6", read_data_2, 32'h0);
        check("reset_sext_ori", Sign_extend, 32'h0000_8001);
        @(posedge clock); #1;
        check("reset_rt6_after_edge", read_data_2, 32'h0);
        @(negedge clock);
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            Instruction = rtype(6'h00, 5'(i), 5'(31 - i), 5'd0);
            #1;
            check($sformatf("post_reset_rs%0d", i), read_data_1, 32'h0);
            check($sformatf("post_reset_rt%0d", 31 - i), read_data_2, 32'h0);
        end

        // Each vector is checked before the rising edge that commits its write.
        add("rtype_wr8",  rtype(6'h00, 5'd8, 5'd0, 5'd8), 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 1,
            32'h0, 32'h0, 32'h0000_4000);
        add("rd_r8",      rtype(6'h00, 5'd8, 5'd9, 5'd0), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'hDEAD_BEEF, 32'h0, 32'h0);
        add("lw_wr9",     itype(6'h23, 5'd8, 5'd9, 16'h0), 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 0, 1, 1, 0,
            32'hDEAD_BEEF, 32'h0, 32'h0);
        add("rd_r9_r8",   rtype(6'h00, 5'd9, 5'd8, 5'd0), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h1234_5678, 32'hDEAD_BEEF, 32'h0);
        add("lw_wr0",     itype(6'h23, 5'd0, 5'd0, 16'h0), 32'hCAFE_F00D, 32'h0, 32'h0, 0, 1, 1, 0,
            32'h0, 32'h0, 32'h0);
        add("rd_r0_r9",   rtype(6'h00, 5'd0, 5'd9, 5'd0), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h1234_5678, 32'h0);
        add("jal",        rtype(6'h03, 5'd0, 5'd0, 5'd4), 32'h0000_0099, 32'h0000_0055, 32'h0000_0011,
            1, 0, 1, 1, 32'h0, 32'h0, 32'h0000_2000);
        add("jr_r31_r4",  rtype(6'h00, 5'd31, 5'd4, 5'd0), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0000_0011, 32'h0, 32'h0);
        add("wr10_a",     rtype(6'h00, 5'd10, 5'd10, 5'd10), 32'h0, 32'h0BAD_F00D, 32'h0, 0, 1, 0, 1,
            32'h0, 32'h0, 32'h0000_5000);
        add("wr10_b",     rtype(6'h00, 5'd10, 5'd10, 5'd10), 32'h0, 32'h0000_0077, 32'h0, 0, 1, 0, 1,
            32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0000_5000);
        add("rd_r10",     rtype(6'h00, 5'd10, 5'd31, 5'd0), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0000_0077, 32'h0000_0011, 32'h0);
        add("addi_ext",   itype(6'h08, 5'd8, 5'd9, 16'h8001), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_8001);
        add("ori_ext",    itype(6'h0D, 5'd0, 5'd0, 16'h8001), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'h0000_8001);
        add("andi_ext",   itype(6'h0C, 5'd0, 5'd0, 16'hFFFF), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'h0000_FFFF);
        add("xori_ext",   itype(6'h0E, 5'd0, 5'd0, 16'hFFFF), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'h0000_FFFF);
        add("lw_ext",     itype(6'h23, 5'd0, 5'd0, 16'h7FFF), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'h0000_7FFF);
        add("lui_ext",    itype(6'h0F, 5'd0, 5'd0, 16'h8000), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'hFFFF_8000);
        add("sltiu_ext",  itype(6'h0B, 5'd0, 5'd0, 16'hFFFF), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'hFFFF_FFFF);
        add("op0f_ext",   itype(6'h0F, 5'd0, 5'd0, 16'hFFFF), 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            32'h0, 32'h0, 32'hFFFF_FFFF);
        add("wr8_a5",     rtype(6'h00, 5'd8, 5'd0, 5'd8), 32'h0, 32'hA5A5_A5A5, 32'h0, 0, 1, 0, 1,
            32'hDEAD_BEEF, 32'h0, 32'h0000_4000);

        foreach (vecs[k]) begin
            @(negedge clock);
            drive(vecs[k].instr, vecs[k].rdata, vecs[k].alu, vecs[k].opc4,
                  vecs[k].jal, vecs[k].rw, vecs[k].m2r, vecs[k].rdst);
            #1;
            check({vecs[k].name, "_rd1"}, read_data_1, vecs[k].e1);
            check({vecs[k].name, "_rd2"}, read_data_2, vecs[k].e2);
            check({vecs[k].name, "_sext"}, Sign_extend, vecs[k].esx);
        end

        // Reset asserted between edges while a write to reg8 is pending.
        @(negedge clock);
        drive(rtype(6'h00, 5'd8, 5'd31, 5'd8), 32'h0, 32'h0000_0001, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        #1;
        check("midrst_before_r8", read_data_1, 32'hA5A5_A5A5);
        #1 reset = 1'b0;
        #1;
        check("midrst_now_r8", read_data_1, 32'h0);
        check("midrst_now_r31", read_data_2, 32'h0);
        @(posedge clock); #1;
        check("midrst_edge_r8", read_data_1, 32'h0);
        @(negedge clock);
        RegWrite = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_release_r8", read_data_1, 32'h0);
        @(posedge clock); #1;
        check("midrst_idle_edge_r8", read_data_1, 32'h0);
        @(negedge clock);
        RegWrite = 1'b1;
        #1;
        check("midrst_pre_write_r8", read_data_1, 32'h0);
        @(posedge clock); #1;
        check("midrst_write_r8", read_data_1, 32'h0000_0001);
        @(negedge clock);
        RegWrite = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
